// File: rtl/uart_rx_frame_if.sv
// Consumer-facing side of uart_rx_frame: received word, per-word error
// flags, sticky overrun and the valid/ready handshake.
interface uart_rx_frame_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              parity_err;
    logic              frame_err;
    logic              overrun;

    modport master (
        output rx_data,
        output rx_valid,
        output parity_err,
        output frame_err,
        output overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  parity_err,
        input  frame_err,
        input  overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: line synchroniser, mid-bit sampling FSM and
// a valid/ready output register carrying parity/framing/overrun status.
module uart_rx_frame #(
    parameter int DATA_W      = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int BAUD_W      = 20,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_en,
    input  logic [BAUD_W-1:0] baud_div,
    input  logic              rx_in,
    output logic              busy,
    uart_rx_frame_if.master   rx_if
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    localparam logic [3:0] LAST_DATA = 4'(DATA_W - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic       HAS_PAR   = (PARITY != 0);
    localparam logic       ODD       = (PARITY == 2);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [2:0]             r_state;
    logic [BAUD_W-1:0]      r_cnt;
    logic [3:0]             r_bit;
    logic [DATA_W-1:0]      r_shift;
    logic                   r_par;
    logic                   r_perr;
    logic                   r_ferr;

    logic [DATA_W-1:0]      r_data;
    logic                   r_valid;
    logic                   r_perr_o;
    logic                   r_ferr_o;
    logic                   r_ovr;

    logic                   w_rxs;
    logic                   w_fall;
    logic [BAUD_W-1:0]      w_bd;
    logic [BAUD_W-1:0]      w_tgt;
    logic                   w_tick;
    logic                   w_ferr;
    logic                   w_load;
    logic                   w_hs;

    assign w_rxs  = r_sync[SYNC_STAGES-1];
    assign w_fall = r_prev & ~w_rxs;

    // START waits half a bit so every later sample lands mid-bit
    assign w_bd   = (baud_div < BAUD_W'(4)) ? BAUD_W'(4) : baud_div;
    assign w_tgt  = (r_state == S_START) ? (w_bd >> 1)
                                         : (w_bd - BAUD_W'(1));
    assign w_tick = (r_cnt == w_tgt);

    assign w_ferr = r_ferr | ~w_rxs;
    assign w_load = rx_en & w_tick & (r_state == S_STOP)
                  & (r_bit == LAST_STOP);
    assign w_hs   = r_valid & rx_if.rx_ready;

    assign busy             = (r_state != S_IDLE);
    assign rx_if.rx_data    = r_data;
    assign rx_if.rx_valid   = r_valid;
    assign rx_if.parity_err = r_perr_o;
    assign rx_if.frame_err  = r_ferr_o;
    assign rx_if.overrun    = r_ovr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx_in};
            r_prev <= w_rxs;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
        end else if (!rx_en) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_fall) begin
                r_state <= S_START;
                r_cnt   <= '0;
                r_bit   <= '0;
                r_par   <= 1'b0;
                r_perr  <= 1'b0;
                r_ferr  <= 1'b0;
            end
        end else if (!w_tick) begin
            r_cnt <= r_cnt + BAUD_W'(1);
        end else begin
            r_cnt <= '0;
            unique case (r_state)
                S_START: r_state <= w_rxs ? S_IDLE : S_DATA;
                S_DATA: begin
                    r_shift <= {w_rxs, r_shift[DATA_W-1:1]};
                    r_par   <= r_par ^ w_rxs;
                    if (r_bit == LAST_DATA) begin
                        r_bit   <= '0;
                        r_state <= HAS_PAR ? S_PAR : S_STOP;
                    end else begin
                        r_bit <= r_bit + 4'd1;
                    end
                end
                S_PAR: begin
                    r_perr  <= r_par ^ w_rxs ^ ODD;
                    r_state <= S_STOP;
                end
                S_STOP: begin
                    r_ferr <= w_ferr;
                    if (r_bit == LAST_STOP) begin
                        r_bit   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_bit <= r_bit + 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_perr_o <= 1'b0;
            r_ferr_o <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            if (w_load && r_valid && !rx_if.rx_ready)
                r_ovr <= 1'b1;
            else if (w_hs)
                r_ovr <= 1'b0;

            if (w_load && (!r_valid || rx_if.rx_ready)) begin
                r_data   <= r_shift;
                r_perr_o <= r_perr;
                r_ferr_o <= w_ferr;
                r_valid  <= 1'b1;
            end else if (w_hs) begin
                r_valid <= 1'b0;
            end
        end
    end
endmodule
